// File: rtl/axi4_mem_arb_if.sv
// One AXI4 port (AW/W/B/AR/R) as seen between a requester and a memory.
// The "master" modport drives requests; the "slave" modport answers them.
interface axi4_mem_arb_if #(
  parameter int DATA_W           = 256,
  parameter int ADDR_W           = 32,
  parameter int MST_ID_W         = 5,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int TRANS_RESP_W     = 2
);
  logic [MST_ID_W-1:0]         awid;
  logic [ADDR_W-1:0]           awaddr;
  logic [1:0]                  awburst;
  logic [TRANS_DATA_LEN_W-1:0] awlen;
  logic                        awvalid;
  logic                        awready;

  logic [DATA_W-1:0]           wdata;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  logic [MST_ID_W-1:0]         bid;
  logic [TRANS_RESP_W-1:0]     bresp;
  logic                        bvalid;
  logic                        bready;

  logic [MST_ID_W-1:0]         arid;
  logic [ADDR_W-1:0]           araddr;
  logic [1:0]                  arburst;
  logic [TRANS_DATA_LEN_W-1:0] arlen;
  logic                        arvalid;
  logic                        arready;

  logic [MST_ID_W-1:0]         rid;
  logic [DATA_W-1:0]           rdata;
  logic [TRANS_RESP_W-1:0]     rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awid, awaddr, awburst, awlen, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arburst, arlen, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awburst, awlen, awvalid, output awready,
    input  wdata, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arburst, arlen, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_mem_arb.sv
// Two-master AXI4 arbiter onto one memory port. Independent round-robin write
// and read paths; each grant is held until its transaction fully completes.
module axi4_mem_arb (
  input  logic           clk,
  input  logic           rst_n,
  axi4_mem_arb_if.slave  m0,
  axi4_mem_arb_if.slave  m1,
  axi4_mem_arb_if.master s
);

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;
  logic      wr_gnt, wr_gnt_nxt, wr_prio, wr_prio_nxt;
  logic      rd_gnt, rd_gnt_nxt, rd_prio, rd_prio_nxt;

  logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  // Handshakes of the currently granted master; only consulted in their own state.
  assign aw_hs     = (wr_gnt ? m1.awvalid : m0.awvalid) & s.awready;
  assign w_last_hs = (wr_gnt ? (m1.wvalid & m1.wlast) : (m0.wvalid & m0.wlast)) & s.wready;
  assign b_hs      = s.bvalid & (wr_gnt ? m1.bready : m0.bready);
  assign ar_hs     = (rd_gnt ? m1.arvalid : m0.arvalid) & s.arready;
  assign r_last_hs = s.rvalid & s.rlast & (rd_gnt ? m1.rready : m0.rready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      wr_gnt   <= 1'b0;
      wr_prio  <= 1'b0;
      rd_state <= RD_IDLE;
      rd_gnt   <= 1'b0;
      rd_prio  <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_gnt   <= wr_gnt_nxt;
      wr_prio  <= wr_prio_nxt;
      rd_state <= rd_state_nxt;
      rd_gnt   <= rd_gnt_nxt;
      rd_prio  <= rd_prio_nxt;
    end
  end

  // Priority flips to the other master only once a transaction has completed.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_gnt_nxt   = wr_gnt;
    wr_prio_nxt  = wr_prio;
    case (wr_state)
      WR_IDLE:
        if (m0.awvalid || m1.awvalid) begin
          wr_gnt_nxt   = (m0.awvalid && m1.awvalid) ? wr_prio : m1.awvalid;
          wr_state_nxt = WR_ADDR;
        end
      WR_ADDR: if (aw_hs) wr_state_nxt = WR_DATA;
      WR_DATA: if (w_last_hs) wr_state_nxt = WR_RESP;
      WR_RESP:
        if (b_hs) begin
          wr_state_nxt = WR_IDLE;
          wr_prio_nxt  = ~wr_gnt;
        end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_gnt_nxt   = rd_gnt;
    rd_prio_nxt  = rd_prio;
    case (rd_state)
      RD_IDLE:
        if (m0.arvalid || m1.arvalid) begin
          rd_gnt_nxt   = (m0.arvalid && m1.arvalid) ? rd_prio : m1.arvalid;
          rd_state_nxt = RD_ADDR;
        end
      RD_ADDR: if (ar_hs) rd_state_nxt = RD_DATA;
      RD_DATA:
        if (r_last_hs) begin
          rd_state_nxt = RD_IDLE;
          rd_prio_nxt  = ~rd_gnt;
        end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    s.awid    = '0;
    s.awaddr  = '0;
    s.awburst = '0;
    s.awlen   = '0;
    s.awvalid = 1'b0;
    s.wdata   = '0;
    s.wlast   = 1'b0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bid     = '0;
    m0.bresp   = '0;
    m0.bvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bid     = '0;
    m1.bresp   = '0;
    m1.bvalid  = 1'b0;
    case (wr_state)
      WR_ADDR:
        if (wr_gnt) begin
          s.awid     = m1.awid;
          s.awaddr   = m1.awaddr;
          s.awburst  = m1.awburst;
          s.awlen    = m1.awlen;
          s.awvalid  = m1.awvalid;
          m1.awready = s.awready;
        end else begin
          s.awid     = m0.awid;
          s.awaddr   = m0.awaddr;
          s.awburst  = m0.awburst;
          s.awlen    = m0.awlen;
          s.awvalid  = m0.awvalid;
          m0.awready = s.awready;
        end
      WR_DATA:
        if (wr_gnt) begin
          s.wdata   = m1.wdata;
          s.wlast   = m1.wlast;
          s.wvalid  = m1.wvalid;
          m1.wready = s.wready;
        end else begin
          s.wdata   = m0.wdata;
          s.wlast   = m0.wlast;
          s.wvalid  = m0.wvalid;
          m0.wready = s.wready;
        end
      WR_RESP:
        if (wr_gnt) begin
          m1.bid    = s.bid;
          m1.bresp  = s.bresp;
          m1.bvalid = s.bvalid;
          s.bready  = m1.bready;
        end else begin
          m0.bid    = s.bid;
          m0.bresp  = s.bresp;
          m0.bvalid = s.bvalid;
          s.bready  = m0.bready;
        end
      default: ;
    endcase
  end

  always_comb begin
    s.arid    = '0;
    s.araddr  = '0;
    s.arburst = '0;
    s.arlen   = '0;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    m0.arready = 1'b0;
    m0.rid     = '0;
    m0.rdata   = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m0.rvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rid     = '0;
    m1.rdata   = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;
    m1.rvalid  = 1'b0;
    case (rd_state)
      RD_ADDR:
        if (rd_gnt) begin
          s.arid     = m1.arid;
          s.araddr   = m1.araddr;
          s.arburst  = m1.arburst;
          s.arlen    = m1.arlen;
          s.arvalid  = m1.arvalid;
          m1.arready = s.arready;
        end else begin
          s.arid     = m0.arid;
          s.araddr   = m0.araddr;
          s.arburst  = m0.arburst;
          s.arlen    = m0.arlen;
          s.arvalid  = m0.arvalid;
          m0.arready = s.arready;
        end
      RD_DATA:
        if (rd_gnt) begin
          m1.rid    = s.rid;
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
          m1.rlast  = s.rlast;
          m1.rvalid = s.rvalid;
          s.rready  = m1.rready;
        end else begin
          m0.rid    = s.rid;
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
          m0.rlast  = s.rlast;
          m0.rvalid = s.rvalid;
          s.rready  = m0.rready;
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_mem_arb.sv
// Directed self-checking bench for axi4_mem_arb: the bench plays both masters
// and the memory, drives after each rising edge and checks mid-cycle.
module tb_axi4_mem_arb;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  axi4_mem_arb_if m0_if ();
  axi4_mem_arb_if m1_if ();
  axi4_mem_arb_if s_if ();

  axi4_mem_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then step off it so the next inputs land mid-cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setAw(input int m, input logic v, input logic [4:0] id,
                       input logic [31:0] addr, input logic [7:0] len);
    if (m == 1) begin
      m1_if.awvalid = v; m1_if.awid = id; m1_if.awaddr = addr; m1_if.awlen = len; m1_if.awburst = 2'b01;
    end else begin
      m0_if.awvalid = v; m0_if.awid = id; m0_if.awaddr = addr; m0_if.awlen = len; m0_if.awburst = 2'b01;
    end
  endtask

  task automatic setAr(input int m, input logic v, input logic [4:0] id,
                       input logic [31:0] addr, input logic [7:0] len);
    if (m == 1) begin
      m1_if.arvalid = v; m1_if.arid = id; m1_if.araddr = addr; m1_if.arlen = len; m1_if.arburst = 2'b01;
    end else begin
      m0_if.arvalid = v; m0_if.arid = id; m0_if.araddr = addr; m0_if.arlen = len; m0_if.arburst = 2'b01;
    end
  endtask

  task automatic setW(input int m, input logic v, input logic [255:0] data, input logic last);
    if (m == 1) begin
      m1_if.wvalid = v; m1_if.wdata = data; m1_if.wlast = last;
    end else begin
      m0_if.wvalid = v; m0_if.wdata = data; m0_if.wlast = last;
    end
  endtask

  task automatic clearInputs();
    setAw(0, 0, 0, 0, 0); setAw(1, 0, 0, 0, 0);
    setAr(0, 0, 0, 0, 0); setAr(1, 0, 0, 0, 0);
    setW(0, 0, 0, 0);     setW(1, 0, 0, 0);
    m0_if.bready = 0; m0_if.rready = 0; m1_if.bready = 0; m1_if.rready = 0;
    s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
    s_if.bvalid = 0; s_if.bid = 0; s_if.bresp = 0;
    s_if.rvalid = 0; s_if.rid = 0; s_if.rdata = 0; s_if.rresp = 0; s_if.rlast = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus();
  endtask

  // Entered one step after the edge that moved the write FSM to WR_ADDR for master m.
  task automatic wrAddrPhase(input int m, input logic [4:0] id, input logic [31:0] addr);
    #1;
    checkOutput("wr_s_awvalid", s_if.awvalid, 1);
    checkOutput("wr_s_awid", s_if.awid, id);
    checkOutput("wr_s_awaddr", s_if.awaddr, addr);
    checkOutput("wr_awready_owner", (m == 1) ? m1_if.awready : m0_if.awready, 1);
    checkOutput("wr_awready_other", (m == 1) ? m0_if.awready : m1_if.awready, 0);
    applyStimulus();
    setAw(m, 0, 0, 0, 0);
  endtask

  task automatic wrDataPhase(input int m, input int len, input logic [255:0] base);
    for (int i = 0; i <= len; i++) begin
      setW(m, 1, base + 256'(i), (i == len));
      #1;
      checkOutput("wr_s_wvalid", s_if.wvalid, 1);
      checkOutput("wr_s_wdata", s_if.wdata, base + 256'(i));
      checkOutput("wr_s_wlast", s_if.wlast, (i == len));
      checkOutput("wr_wready_owner", (m == 1) ? m1_if.wready : m0_if.wready, 1);
      checkOutput("wr_wready_other", (m == 1) ? m0_if.wready : m1_if.wready, 0);
      applyStimulus();
    end
    setW(m, 0, 0, 0);
  endtask

  task automatic wrRespPhase(input int m, input logic [4:0] id, input logic [1:0] resp);
    if (m == 1) m1_if.bready = 1; else m0_if.bready = 1;
    s_if.bvalid = 1; s_if.bid = id; s_if.bresp = resp;
    #1;
    checkOutput("wr_bvalid_owner", (m == 1) ? m1_if.bvalid : m0_if.bvalid, 1);
    checkOutput("wr_bid_owner", (m == 1) ? m1_if.bid : m0_if.bid, id);
    checkOutput("wr_bresp_owner", (m == 1) ? m1_if.bresp : m0_if.bresp, resp);
    checkOutput("wr_bvalid_other", (m == 1) ? m0_if.bvalid : m1_if.bvalid, 0);
    checkOutput("wr_s_bready", s_if.bready, 1);
    applyStimulus();
    s_if.bvalid = 0;
    #1;
    checkOutput("wr_idle_s_bready", s_if.bready, 0);
    checkOutput("wr_idle_s_awvalid", s_if.awvalid, 0);
  endtask

  initial begin
    int ids [2];
    int pat [7];
    int g;
    int b;
    compared   = 0;
    mismatched = 0;

    // Reset state and a single 4-beat write from m0
    doReset();
    checkOutput("rst_s_awvalid", s_if.awvalid, 0);
    checkOutput("rst_s_arvalid", s_if.arvalid, 0);
    checkOutput("rst_s_bready", s_if.bready, 0);
    checkOutput("rst_m0_awready", m0_if.awready, 0);
    checkOutput("rst_m1_arready", m1_if.arready, 0);
    setAw(0, 1, 5, 32'h40, 3);
    #1;
    checkOutput("t1_arb_cycle_awvalid", s_if.awvalid, 0);
    checkOutput("t1_arb_cycle_awready", m0_if.awready, 0);
    applyStimulus();
    wrAddrPhase(0, 5, 32'h40);
    wrDataPhase(0, 3, 256'hA0);
    wrRespPhase(0, 5, 2'b00);

    // Simultaneous AW from both masters: m0 first, bubble, then m1
    doReset();
    setAw(0, 1, 3, 32'h100, 0);
    setAw(1, 1, 9, 32'h200, 1);
    applyStimulus();
    wrAddrPhase(0, 3, 32'h100);
    wrDataPhase(0, 0, 256'h10);
    wrRespPhase(0, 3, 2'b01);
    checkOutput("t2_bubble_m1_awready", m1_if.awready, 0);
    applyStimulus();
    wrAddrPhase(1, 9, 32'h200);
    wrDataPhase(1, 1, 256'h20);
    wrRespPhase(1, 9, 2'b00);
    setAw(0, 1, 4, 32'h300, 0);
    setAw(1, 1, 10, 32'h400, 0);
    applyStimulus();
    #1;
    checkOutput("t2_prio_back_m0_awid", s_if.awid, 4);
    checkOutput("t2_prio_back_m0_awready", m0_if.awready, 1);
    checkOutput("t2_prio_back_m1_awready", m1_if.awready, 0);
    setAw(1, 0, 0, 0, 0);
    applyStimulus();
    setAw(0, 0, 0, 0, 0);
    wrDataPhase(0, 0, 256'h30);
    wrRespPhase(0, 4, 2'b00);

    // m0 reads 8 beats while m1 writes 2 beats, concurrently
    setAr(0, 1, 7, 32'h1000, 7);
    setAw(1, 1, 12, 32'h2000, 1);
    applyStimulus();
    #1;
    checkOutput("t3_s_arvalid", s_if.arvalid, 1);
    checkOutput("t3_s_arid", s_if.arid, 7);
    checkOutput("t3_s_awvalid", s_if.awvalid, 1);
    checkOutput("t3_s_awid", s_if.awid, 12);
    checkOutput("t3_m0_arready", m0_if.arready, 1);
    checkOutput("t3_m1_awready", m1_if.awready, 1);
    applyStimulus();
    setAr(0, 0, 0, 0, 0);
    setAw(1, 0, 0, 0, 0);
    m0_if.rready = 1;
    m1_if.bready = 1;
    for (int i = 0; i < 8; i++) begin
      s_if.rvalid = 1; s_if.rid = 7; s_if.rdata = 256'h500 + 256'(i); s_if.rlast = (i == 7);
      if (i < 2) setW(1, 1, 256'h900 + 256'(i), (i == 1));
      else setW(1, 0, 0, 0);
      s_if.bvalid = (i == 2); s_if.bid = 12; s_if.bresp = 2'b00;
      #1;
      checkOutput("t3_m0_rvalid", m0_if.rvalid, 1);
      checkOutput("t3_m0_rid", m0_if.rid, 7);
      checkOutput("t3_m0_rdata", m0_if.rdata, 256'h500 + 256'(i));
      checkOutput("t3_m0_rlast", m0_if.rlast, (i == 7));
      checkOutput("t3_m1_rvalid", m1_if.rvalid, 0);
      if (i < 2) checkOutput("t3_s_wdata", s_if.wdata, 256'h900 + 256'(i));
      if (i == 2) checkOutput("t3_m1_bvalid", m1_if.bvalid, 1);
      if (i == 2) checkOutput("t3_m1_bid", m1_if.bid, 12);
      applyStimulus();
    end
    s_if.rvalid = 0;
    s_if.bvalid = 0;
    #1;
    checkOutput("t3_done_s_rready", s_if.rready, 0);
    checkOutput("t3_done_s_bready", s_if.bready, 0);

    // Six back-to-back contended single-beat reads alternate m0/m1
    doReset();
    ids[0] = 1;
    ids[1] = 2;
    m0_if.rready = 1;
    m1_if.rready = 1;
    setAr(0, 1, 5'(ids[0]), 32'h4000, 0);
    setAr(1, 1, 5'(ids[1]), 32'h5000, 0);
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      #1;
      checkOutput("t4_idle_s_arvalid", s_if.arvalid, 0);
      applyStimulus();
      #1;
      checkOutput("t4_grant_arid", s_if.arid, 5'(ids[g]));
      checkOutput("t4_arready_owner", (g == 1) ? m1_if.arready : m0_if.arready, 1);
      checkOutput("t4_arready_other", (g == 1) ? m0_if.arready : m1_if.arready, 0);
      applyStimulus();
      s_if.rvalid = 1; s_if.rid = 5'(ids[g]); s_if.rdata = 256'(k); s_if.rlast = 1;
      #1;
      checkOutput("t4_rvalid_owner", (g == 1) ? m1_if.rvalid : m0_if.rvalid, 1);
      checkOutput("t4_rid_owner", (g == 1) ? m1_if.rid : m0_if.rid, 5'(ids[g]));
      checkOutput("t4_rvalid_other", (g == 1) ? m0_if.rvalid : m1_if.rvalid, 0);
      applyStimulus();
      s_if.rvalid = 0;
    end
    setAr(0, 0, 0, 0, 0);
    setAr(1, 0, 0, 0, 0);

    // m1 read of 4 beats with rready low for 3 cycles after beat 2
    applyStimulus();
    setAr(1, 1, 3, 32'h3000, 3);
    applyStimulus();
    applyStimulus();
    setAr(1, 0, 0, 0, 0);
    pat = '{1, 1, 0, 0, 0, 1, 1};
    b = 0;
    for (int c = 0; c < 7; c++) begin
      s_if.rvalid = 1; s_if.rid = 3; s_if.rdata = 256'h700 + 256'(b); s_if.rlast = (b == 3);
      m1_if.rready = pat[c][0];
      #1;
      checkOutput("t5_s_rready", s_if.rready, pat[c][0]);
      checkOutput("t5_m1_rvalid", m1_if.rvalid, 1);
      checkOutput("t5_m1_rdata", m1_if.rdata, 256'h700 + 256'(b));
      checkOutput("t5_m1_rlast", m1_if.rlast, (b == 3));
      applyStimulus();
      if (pat[c] != 0) b++;
    end
    #1;
    checkOutput("t5_after_last_s_rready", s_if.rready, 0);
    checkOutput("t5_after_last_m1_rvalid", m1_if.rvalid, 0);
    s_if.rvalid = 0;
    m1_if.rready = 0;

    // Reset during beat 2 of a 4-beat m0 write, then a clean m1 write
    doReset();
    setAw(0, 1, 6, 32'h600, 3);
    applyStimulus();
    applyStimulus();
    setAw(0, 0, 0, 0, 0);
    setW(0, 1, 256'hB0, 0);
    applyStimulus();
    setW(0, 1, 256'hB1, 0);
    #1;
    checkOutput("t6_beat2_s_wvalid", s_if.wvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_s_wvalid", s_if.wvalid, 0);
    checkOutput("t6_rst_s_wdata", s_if.wdata, 0);
    checkOutput("t6_rst_m0_wready", m0_if.wready, 0);
    checkOutput("t6_rst_s_awvalid", s_if.awvalid, 0);
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();
    setAw(1, 1, 11, 32'h700, 1);
    #1;
    checkOutput("t6_arb_cycle_awvalid", s_if.awvalid, 0);
    applyStimulus();
    wrAddrPhase(1, 11, 32'h700);
    wrDataPhase(1, 1, 256'hC0);
    wrRespPhase(1, 11, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
